mux_arbiter_2: RTL and testbench
================================

MUX_ARBITER_2 -- requirements
Module: mux_arbiter_2

Interface
REQ-001 Parameter WIDTH, default 8, data width of both requester inputs and the shared output.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles before a contended owner SHALL be preempted; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_a  input  1  requester A wants the shared channel.
REQ-006 req_b  input  1  requester B wants the shared channel.
REQ-007 a  input  WIDTH  requester A data.
REQ-008 b  input  WIDTH  requester B data.
REQ-009 gnt_a  output  1  registered grant to A.
REQ-010 gnt_b  output  1  registered grant to B.
REQ-011 s  output  1  mux select; 1 selects a, 0 selects b.
REQ-012 f  output  WIDTH  registered shared-channel data.
REQ-013 f_valid  output  1  f carries granted data this cycle.

Function
REQ-014 States SHALL be IDLE, OWN_A, OWN_B; gnt_a=1 exactly in OWN_A, gnt_b=1 exactly in OWN_B; gnt_a and gnt_b SHALL never both be 1.
REQ-015 Grant latency SHALL be one cycle: a req sampled high at edge N yields the grant after edge N, never combinationally.
REQ-016 A last-served flag (last) SHALL record the most recent owner; it updates on every entry to OWN_A/OWN_B.
REQ-017 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the requester not equal to last; neither -> stay IDLE.
REQ-018 hold_cnt (width ceil(log2(MAX_HOLD)) bits) SHALL clear to 0 on entry to an OWN state and increment each cycle in it, saturating at MAX_HOLD-1.
REQ-019 OWN_A: req_a low -> OWN_B if req_b, else IDLE; req_a high and hold_cnt==MAX_HOLD-1 and req_b -> OWN_B; otherwise stay OWN_A.
REQ-020 OWN_B SHALL mirror REQ-019 with A and B swapped.
REQ-021 Direct OWN_A<->OWN_B handover SHALL occur with no IDLE bubble cycle.
REQ-022 Owner alone with no contender SHALL keep the grant indefinitely (counter saturated, no preemption).
REQ-023 s SHALL be 1 in OWN_A, 0 in OWN_B, and hold its previous value in IDLE.
REQ-024 Each edge in OWN_A: f <= a, f_valid <= 1; in OWN_B: f <= b, f_valid <= 1; in IDLE: f holds, f_valid <= 0 (data latency one cycle after grant).
REQ-025 A requester dropping req while granted SHALL still have that final grant cycle's data registered to f; grant removal takes effect at the next edge.
REQ-026 Data inputs of the non-granted requester SHALL never reach f.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force state=IDLE, gnt_a=0, gnt_b=0, s=0, f=0, f_valid=0, hold_cnt=0, last=B (so A wins the first tie).
REQ-028 Reset asserted mid-grant SHALL abort the grant with no further f update; after release, arbitration restarts from REQ-027 values on the first edge with rst_n high.

Verification
REQ-029 Reset, then req_a=1,req_b=1 same cycle, a=8'h11,b=8'h22 -> gnt_a=1 after first edge, s=1, f=8'h11 with f_valid=1 one edge later.
REQ-030 Both requesting continuously, MAX_HOLD=4 -> grant alternates A x4, B x4, A x4; gnt changes with no IDLE cycle; never both grants high.
REQ-031 req_a=1 alone for 10 cycles -> gnt_a stays 1 all 10 cycles, hold_cnt saturates at 3, no preemption.
REQ-032 In OWN_A drop req_a with req_b=1, b=8'h5A -> gnt_b=1 next edge, s=0, f=8'h5A one edge later; then drop req_b -> IDLE, f_valid=0, s stays 0, f holds 8'h5A.
REQ-033 rst_n pulsed low for half a cycle while gnt_b=1 -> gnt_b, f_valid, f go 0 immediately without a clock edge; after release with both req high, A is granted first.
REQ-034 Random req/data for 10k cycles -> scoreboard confirms grant mutex, one-cycle latency, f equals granted requester's data from prior cycle, no owner exceeds MAX_HOLD consecutive cycles while the other requests.

Source files
------------

// File: rtl/mux_arbiter_2.sv
// Two-requester arbiter driving a shared registered data channel.
// Ties go to whichever requester was not served last; a contended owner is preempted after MAX_HOLD cycles.
module mux_arbiter_2 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] f,
  output logic             f_valid
);

  // state | meaning
  // IDLE  | nobody owns the channel, f holds, f_valid low
  // OWN_A | A granted, f <= a each edge
  // OWN_B | B granted, f <= b each edge
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e           state_q, state_d;
  logic             last_a_q, last_a_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             f_valid_q, f_valid_d;

  always_comb begin
    state_d    = state_q;
    last_a_d   = last_a_q;
    hold_cnt_d = hold_cnt_q;
    s_d        = s_q;
    f_d        = f_q;
    f_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_a_q ? OWN_B : OWN_A;
        else if (req_a)     state_d = OWN_A;
        else if (req_b)     state_d = OWN_B;
      end
      OWN_A: begin
        f_d       = a;
        f_valid_d = 1'b1;
        if (!req_a)                              state_d = req_b ? OWN_B : IDLE;
        else if (req_b && hold_cnt_q == CNT_MAX) state_d = OWN_B;
      end
      OWN_B: begin
        f_d       = b;
        f_valid_d = 1'b1;
        if (!req_b)                              state_d = req_a ? OWN_A : IDLE;
        else if (req_a && hold_cnt_q == CNT_MAX) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase

    // Entering an owner state restarts the hold window and records the owner.
    if (state_d != state_q && state_d != IDLE) begin
      hold_cnt_d = '0;
      last_a_d   = (state_d == OWN_A);
    end else if (state_d == state_q && state_q != IDLE && hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (state_d == OWN_A)      s_d = 1'b1;
    else if (state_d == OWN_B) s_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_a_q   <= 1'b0;
      hold_cnt_q <= '0;
      s_q        <= 1'b0;
      f_q        <= '0;
      f_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_a_q   <= last_a_d;
      hold_cnt_q <= hold_cnt_d;
      s_q        <= s_d;
      f_q        <= f_d;
      f_valid_q  <= f_valid_d;
    end
  end

  assign gnt_a   = (state_q == OWN_A);
  assign gnt_b   = (state_q == OWN_B);
  assign s       = s_q;
  assign f       = f_q;
  assign f_valid = f_valid_q;

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Bench for mux_arbiter_2: directed scenarios followed by random traffic,
// all checked against an ownership/run-length model of the arbitration rules.
module tb_mux_arbiter_2;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_a, req_b;
  logic [WIDTH-1:0] a, b;
  logic             gnt_a, gnt_b, s, f_valid;
  logic [WIDTH-1:0] f;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner (0 none, 1 A, 2 B), cycles held so far, last served owner.
  int               own;
  int               run;
  bit               last_a;
  logic [WIDTH-1:0] mf;
  bit               mfv;
  bit               ms;

  mux_arbiter_2 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .a(a), .b(b), .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .f(f), .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; run = 0; last_a = 1'b0; mf = '0; mfv = 1'b0; ms = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int hold_exp;
    chk({tag, ".gnt_a"},   32'(gnt_a),   32'(own == 1));
    chk({tag, ".gnt_b"},   32'(gnt_b),   32'(own == 2));
    chk({tag, ".mutex"},   32'(gnt_a & gnt_b), 32'(0));
    chk({tag, ".s"},       32'(s),       32'(ms));
    chk({tag, ".f_valid"}, 32'(f_valid), 32'(mfv));
    chk({tag, ".f"},       32'(f),       32'(mf));
    if (own != 0) begin
      hold_exp = (run - 1 < MAX_HOLD - 1) ? run - 1 : MAX_HOLD - 1;
      chk({tag, ".hold_cnt"}, 32'(dut.hold_cnt_q), 32'(hold_exp));
    end
  endtask

  // Advance model by one edge using the inputs currently applied, then compare.
  task automatic cyc(input string tag);
    int nown;
    if (own == 1)      begin mf = a; mfv = 1'b1; end
    else if (own == 2) begin mf = b; mfv = 1'b1; end
    else               mfv = 1'b0;

    nown = own;
    if (own == 0) begin
      if (req_a && req_b) nown = last_a ? 2 : 1;
      else if (req_a)     nown = 1;
      else if (req_b)     nown = 2;
    end else if (own == 1) begin
      if (!req_a)                      nown = req_b ? 2 : 0;
      else if (req_b && run >= MAX_HOLD) nown = 2;
    end else begin
      if (!req_b)                      nown = req_a ? 1 : 0;
      else if (req_a && run >= MAX_HOLD) nown = 1;
    end

    if (nown != 0 && nown != own) begin
      run = 1;
      last_a = (nown == 1);
    end else if (nown != 0) begin
      run++;
    end
    if (nown == 1)      ms = 1'b1;
    else if (nown == 2) ms = 1'b0;
    own = nown;

    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    model_reset();
    #2;
    chk("rst.gnt_a", 32'(gnt_a), 32'(0));
    chk("rst.gnt_b", 32'(gnt_b), 32'(0));
    chk("rst.s", 32'(s), 32'(0));
    chk("rst.f", 32'(f), 32'(0));
    chk("rst.f_valid", 32'(f_valid), 32'(0));
    #10 rst_n = 1'b1;

    // First tie goes to A; then sustained contention alternates every MAX_HOLD cycles.
    req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22;
    cyc("tie_first");
    chk("tie_first.gnt_a_direct", 32'(gnt_a), 32'(1));
    cyc("tie_data");
    chk("tie_data.f_direct", 32'(f), 32'h11);
    for (int i = 0; i < 12; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cyc("contend");
    end

    // A alone keeps the grant indefinitely with the counter saturated.
    req_b = 1'b0; req_a = 1'b0;
    cyc("drop_both");
    cyc("idle");
    req_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a = WIDTH'($urandom);
      cyc("a_alone");
    end
    chk("a_alone.hold_sat", 32'(dut.hold_cnt_q), 32'(MAX_HOLD - 1));

    // Handover on A release, then B release back to IDLE.
    req_a = 1'b0; req_b = 1'b1; b = 8'h5A;
    cyc("handover");
    cyc("handover_data");
    chk("handover.f_direct", 32'(f), 32'h5A);
    req_b = 1'b0;
    cyc("b_last");
    cyc("idle_hold");
    chk("idle_hold.f_direct", 32'(f), 32'h5A);

    // Asynchronous reset while B owns the channel.
    req_b = 1'b1; b = 8'h77;
    cyc("own_b");
    cyc("own_b_data");
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.gnt_b", 32'(gnt_b), 32'(0));
    chk("async_rst.f_valid", 32'(f_valid), 32'(0));
    chk("async_rst.f", 32'(f), 32'(0));
    chk("async_rst.s", 32'(s), 32'(0));
    model_reset();
    #3 rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    cyc("post_rst_tie");

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      req_a = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 3) != 0);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
